// File: rtl/branch_resolver_if.sv
// Request/response handshake bundle for the branch resolver.
// Request side: valid/ready with condition, flag-set select and tag.
// Response side: registered valid/ready with taken bit and returned tag.
interface branch_resolver_if #(
    parameter int COND_WIDTH = 4,
    parameter int FSEL_W     = 2,
    parameter int TAG_WIDTH  = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [COND_WIDTH-1:0] req_cond;
    logic [FSEL_W-1:0]     req_fsel;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_take;
    logic [TAG_WIDTH-1:0]  resp_tag;

    // Branch stage driving requests and consuming results.
    modport master (
        output req_valid, req_cond, req_fsel, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_take, resp_tag
    );

    // Resolver accepting requests and producing results.
    modport slave (
        input  req_valid, req_cond, req_fsel, req_tag, resp_ready,
        output req_ready, resp_valid, resp_take, resp_tag
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch condition resolver: NZCV flag sets with producer scoreboard and write bypass.
// Latency: one cycle from request accept to registered response.
// Backpressure: req_ready drops on a busy flag set or a held, unconsumed response.
module branch_resolver #(
    parameter int  COND_WIDTH = 4,
    parameter int  FLAG_SETS  = 4,
    parameter int  TAG_WIDTH  = 4,
    parameter int  PERF_WIDTH = 16,
    localparam int FSEL_W     = $clog2(FLAG_SETS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flag_reserve,
    input  logic [FSEL_W-1:0]     flag_rsel,
    input  logic                  flag_we,
    input  logic [FSEL_W-1:0]     flag_wsel,
    input  logic [3:0]            flag_wdata,
    branch_resolver_if.slave      bus,
    output logic [FLAG_SETS-1:0]  busy,
    output logic [PERF_WIDTH-1:0] eval_count,
    output logic [PERF_WIDTH-1:0] taken_count
);

    logic [3:0]            flags_q [FLAG_SETS];
    logic [3:0]            flags_d [FLAG_SETS];
    logic [FLAG_SETS-1:0]  busy_q, busy_d;
    logic                  resp_vld_q, resp_vld_d;
    logic                  resp_take_q, resp_take_d;
    logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;
    logic [PERF_WIDTH-1:0] eval_q, eval_d;
    logic [PERF_WIDTH-1:0] taken_q, taken_d;

    logic       byp_hit;
    logic [3:0] eff_flags;
    logic       hazard;
    logic       ready;
    logic       accept;
    logic       take;

    // Condition table over {N,Z,C,V}; codes 15 and above never take.
    function automatic logic cond_eval(input logic [COND_WIDTH-1:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        r  = 1'b0;
        if (c < COND_WIDTH'(15)) begin
            case (c[3:0])
                4'd0:    r = z;
                4'd1:    r = !z;
                4'd2:    r = cy;
                4'd3:    r = !cy;
                4'd4:    r = n;
                4'd5:    r = !n;
                4'd6:    r = v;
                4'd7:    r = !v;
                4'd8:    r = cy && !z;
                4'd9:    r = !cy || z;
                4'd10:   r = (n == v);
                4'd11:   r = (n != v);
                4'd12:   r = !z && (n == v);
                4'd13:   r = z || (n != v);
                4'd14:   r = 1'b1;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Hazard, bypass and accept decision for the current request.
    always_comb begin
        byp_hit   = flag_we && (flag_wsel == bus.req_fsel);
        eff_flags = byp_hit ? flag_wdata : flags_q[bus.req_fsel];
        hazard    = busy_q[bus.req_fsel] && !byp_hit;
        ready     = !hazard && (!resp_vld_q || bus.resp_ready);
        accept    = bus.req_valid && ready;
        take      = cond_eval(bus.req_cond, eff_flags);
    end

    // Next state: flag sets, scoreboard (reserve beats write), response register, counters.
    always_comb begin
        flags_d     = flags_q;
        busy_d      = busy_q;
        resp_vld_d  = resp_vld_q;
        resp_take_d = resp_take_q;
        resp_tag_d  = resp_tag_q;
        eval_d      = eval_q;
        taken_d     = taken_q;
        if (flag_we) begin
            flags_d[flag_wsel] = flag_wdata;
            busy_d[flag_wsel]  = 1'b0;
        end
        if (flag_reserve) begin
            busy_d[flag_rsel] = 1'b1;
        end
        if (accept) begin
            resp_vld_d  = 1'b1;
            resp_take_d = take;
            resp_tag_d  = bus.req_tag;
            if (eval_q != {PERF_WIDTH{1'b1}}) eval_d = eval_q + PERF_WIDTH'(1);
            if (take && (taken_q != {PERF_WIDTH{1'b1}})) taken_d = taken_q + PERF_WIDTH'(1);
        end else if (bus.resp_ready) begin
            resp_vld_d = 1'b0;
        end
    end

    // State registers; reset drops any pending response and the scoreboard at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FLAG_SETS; i++) flags_q[i] <= 4'b0000;
            busy_q      <= '0;
            resp_vld_q  <= 1'b0;
            resp_take_q <= 1'b0;
            resp_tag_q  <= '0;
            eval_q      <= '0;
            taken_q     <= '0;
        end else begin
            for (int i = 0; i < FLAG_SETS; i++) flags_q[i] <= flags_d[i];
            busy_q      <= busy_d;
            resp_vld_q  <= resp_vld_d;
            resp_take_q <= resp_take_d;
            resp_tag_q  <= resp_tag_d;
            eval_q      <= eval_d;
            taken_q     <= taken_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_vld_q;
    assign bus.resp_take  = resp_take_q;
    assign bus.resp_tag   = resp_tag_q;
    assign busy           = busy_q;
    assign eval_count     = eval_q;
    assign taken_count    = taken_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a cycle-level reference model.
// Two instances share stimulus: full-width counters and a 4-bit counter build.
// Outputs are compared at the falling edge; inputs change 1ns after the rising edge.
module tb_branch_resolver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flag_reserve, flag_we;
    logic [1:0] flag_rsel, flag_wsel;
    logic [3:0] flag_wdata;
    logic       req_valid, resp_ready;
    logic [3:0] req_cond, req_tag;
    logic [1:0] req_fsel;

    logic [3:0]  busy0, busy1;
    logic [15:0] ev0, tk0;
    logic [3:0]  ev1, tk1;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [3:0] m_flags [4];
    logic [3:0] m_busy;
    bit         m_vld, m_take;
    logic [3:0] m_tag;
    int         m_ev, m_tk;
    bit         m_hit, m_rdy, m_t;
    logic [3:0] m_eff;

    always #5 clk = ~clk;

    branch_resolver_if #(.COND_WIDTH(4), .FSEL_W(2), .TAG_WIDTH(4)) if0 ();
    branch_resolver_if #(.COND_WIDTH(4), .FSEL_W(2), .TAG_WIDTH(4)) if1 ();

    assign if0.req_valid  = req_valid;
    assign if0.req_cond   = req_cond;
    assign if0.req_fsel   = req_fsel;
    assign if0.req_tag    = req_tag;
    assign if0.resp_ready = resp_ready;
    assign if1.req_valid  = req_valid;
    assign if1.req_cond   = req_cond;
    assign if1.req_fsel   = req_fsel;
    assign if1.req_tag    = req_tag;
    assign if1.resp_ready = resp_ready;

    branch_resolver #(.COND_WIDTH(4), .FLAG_SETS(4), .TAG_WIDTH(4), .PERF_WIDTH(16)) u0 (
        .clk(clk), .rst_n(rst_n), .flag_reserve(flag_reserve), .flag_rsel(flag_rsel),
        .flag_we(flag_we), .flag_wsel(flag_wsel), .flag_wdata(flag_wdata), .bus(if0),
        .busy(busy0), .eval_count(ev0), .taken_count(tk0));

    branch_resolver #(.COND_WIDTH(4), .FLAG_SETS(4), .TAG_WIDTH(4), .PERF_WIDTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .flag_reserve(flag_reserve), .flag_rsel(flag_rsel),
        .flag_we(flag_we), .flag_wsel(flag_wsel), .flag_wdata(flag_wdata), .bus(if1),
        .busy(busy1), .eval_count(ev1), .taken_count(tk1));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Even codes 0..12 are base conditions; each odd code below 14 is its complement.
    function automatic bit spec_take(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c >= 4'd14) return (c == 4'd14);
        case (c >> 1)
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic int sat(input int x, input int maxv);
        return (x > maxv) ? maxv : x;
    endfunction

    function automatic bit model_ready();
        bit hit;
        hit = flag_we && (flag_wsel == req_fsel);
        return !(m_busy[req_fsel] && !hit) && (!m_vld || resp_ready);
    endfunction

    // Model update at each rising edge from the inputs held during the cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_flags[i] = 4'b0000;
            m_busy = 4'b0000; m_vld = 0; m_take = 0; m_tag = 4'd0; m_ev = 0; m_tk = 0;
        end else begin
            m_hit = flag_we && (flag_wsel == req_fsel);
            m_eff = m_hit ? flag_wdata : m_flags[req_fsel];
            m_rdy = model_ready();
            if (req_valid && m_rdy) begin
                m_t = spec_take(req_cond, m_eff);
                m_vld = 1; m_take = m_t; m_tag = req_tag;
                m_ev++;
                if (m_t) m_tk++;
            end else if (resp_ready) begin
                m_vld = 0;
            end
            if (flag_we) begin
                m_flags[flag_wsel] = flag_wdata;
                m_busy[flag_wsel] = 1'b0;
            end
            if (flag_reserve) m_busy[flag_rsel] = 1'b1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("resp_valid", if0.resp_valid, m_vld);
            chk("resp_valid_p4", if1.resp_valid, m_vld);
            if (m_vld) begin
                chk("resp_take", if0.resp_take, m_take);
                chk("resp_tag", if0.resp_tag, m_tag);
            end
            chk("req_ready", if0.req_ready, model_ready());
            chk("busy", busy0, m_busy);
            chk("eval_count", ev0, sat(m_ev, 65535));
            chk("taken_count", tk0, sat(m_tk, 65535));
            chk("eval_count_p4", ev1, sat(m_ev, 15));
            chk("taken_count_p4", tk1, sat(m_tk, 15));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flag_reserve = 0; flag_rsel = 0; flag_we = 0; flag_wsel = 0; flag_wdata = 0;
        req_valid = 0; req_cond = 0; req_fsel = 0; req_tag = 0; resp_ready = 1;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_resp_valid", if0.resp_valid, 0);
        chk("rst_resp_take", if0.resp_take, 0);
        chk("rst_resp_tag", if0.resp_tag, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_eval", ev0, 0);
        chk("rst_req_ready", if0.req_ready, 1);
        #10;
        rst_n = 1;
        tick();

        // set 1 = {N0,Z1,C1,V0}; cond 9 takes, cond 8 does not
        flag_we = 1; flag_wsel = 1; flag_wdata = 4'b0110;
        tick();
        idle();
        req_valid = 1; req_cond = 9; req_fsel = 1; req_tag = 5;
        tick();
        req_cond = 8; req_tag = 6;
        chk("t1_valid", if0.resp_valid, 1);
        chk("t1_take", if0.resp_take, 1);
        chk("t1_tag", if0.resp_tag, 5);
        tick();
        idle();
        chk("t1b_take", if0.resp_take, 0);
        chk("t1b_tag", if0.resp_tag, 6);
        tick();

        // full code x flag sweep on set 0 from a clean counter state
        pulse_reset();
        for (int f = 0; f < 16; f++) begin
            idle();
            flag_we = 1; flag_wsel = 0; flag_wdata = 4'(f);
            tick();
            idle();
            for (int c = 0; c < 16; c++) begin
                req_valid = 1; req_cond = 4'(c); req_fsel = 0; req_tag = 4'(c);
                tick();
                if (f == 9 && c == 10) chk("sweep_nv_eq", if0.resp_take, 1);
                if (f == 9 && c == 12) chk("sweep_gt", if0.resp_take, 1);
                if (f == 4 && c == 9)  chk("sweep_ls", if0.resp_take, 1);
                if (f == 0 && c == 14) chk("sweep_always", if0.resp_take, 1);
                if (f == 15 && c == 15) chk("sweep_never", if0.resp_take, 0);
            end
        end
        chk("sweep_eval", ev0, 256);
        chk("sweep_taken", tk0, 128);
        chk("sweep_eval_p4", ev1, 15);
        chk("sweep_taken_p4", tk1, 15);
        idle();
        tick();

        // scoreboard stall on set 2, released by a same-cycle write with bypass
        flag_reserve = 1; flag_rsel = 2;
        tick();
        idle();
        req_valid = 1; req_fsel = 2; req_cond = 0; req_tag = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", if0.req_ready, 0);
            tick();
        end
        flag_we = 1; flag_wsel = 2; flag_wdata = 4'b0100;
        #1;
        chk("bypass_ready", if0.req_ready, 1);
        tick();
        idle();
        chk("bypass_valid", if0.resp_valid, 1);
        chk("bypass_take", if0.resp_take, 1);
        chk("bypass_tag", if0.resp_tag, 7);
        chk("bypass_busy2", busy0[2], 0);
        tick();

        // reserve and write set 3 together: newer producer keeps it busy
        flag_reserve = 1; flag_rsel = 3; flag_we = 1; flag_wsel = 3; flag_wdata = 4'b1111;
        tick();
        idle();
        chk("rw_busy3", busy0[3], 1);
        req_valid = 1; req_fsel = 3; req_cond = 14; req_tag = 3;
        #1;
        chk("rw_stall", if0.req_ready, 0);
        tick();
        chk("rw_no_resp", if0.resp_valid, 0);
        flag_we = 1; flag_wsel = 3; flag_wdata = 4'b0000;
        tick();
        idle();
        chk("rw_resp_tag", if0.resp_tag, 3);
        tick();

        // output backpressure: first result held, second waits, both delivered in order
        resp_ready = 0;
        req_valid = 1; req_cond = 14; req_fsel = 0; req_tag = 1;
        tick();
        req_tag = 2;
        #1;
        chk("hold_ready", if0.req_ready, 0);
        tick();
        chk("hold_tag_a", if0.resp_tag, 1);
        chk("hold_valid", if0.resp_valid, 1);
        tick();
        chk("hold_tag_b", if0.resp_tag, 1);
        resp_ready = 1;
        #1;
        chk("release_ready", if0.req_ready, 1);
        tick();
        req_valid = 0;
        chk("second_tag", if0.resp_tag, 2);
        chk("second_valid", if0.resp_valid, 1);
        tick();
        chk("drained", if0.resp_valid, 0);

        // asynchronous reset with a pending response and a busy set
        idle();
        resp_ready = 0;
        flag_reserve = 1; flag_rsel = 1;
        req_valid = 1; req_cond = 14; req_fsel = 0; req_tag = 9;
        tick();
        idle();
        resp_ready = 0;
        chk("pre_rst_valid", if0.resp_valid, 1);
        chk("pre_rst_busy1", busy0[1], 1);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", if0.resp_valid, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_tag", if0.resp_tag, 0);
        chk("arst_eval", ev0, 0);
        chk("arst_taken_p4", tk1, 0);
        rst_n = 1;
        resp_ready = 1;
        tick();

        // counter saturation on the 4-bit build
        req_valid = 1; req_cond = 14; req_fsel = 0;
        for (int i = 0; i < 19; i++) begin
            req_tag = 4'(i);
            tick();
        end
        idle();
        chk("sat_eval_p4", ev1, 15);
        chk("sat_taken_p4", tk1, 15);
        chk("sat_eval", ev0, 19);
        chk("sat_taken", tk0, 19);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Parametrised, pipelined branch-condition resolver for the core's branch stage. It holds FLAG_SETS independent NZCV flag registers with producer scoreboarding and write-to-read bypass. It evaluates the 4-bit condition code against a selected flag set over a valid/ready request/response handshake with one-cycle latency. It also keeps saturating counters of evaluations and taken branches.

## Interface
- COND_WIDTH, 4: width of condition code; codes ≥ 15 evaluate to not-taken.
- FLAG_SETS, 4: number of flag registers (≥ 2); FSEL_W = $clog2(FLAG_SETS).
- TAG_WIDTH, 4: opaque request tag, returned with result.
- PERF_WIDTH, 16: width of performance counters.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flag_reserve  in  1  mark flag set flag_rsel busy (producer in flight).
- flag_rsel  in  FSEL_W  set to reserve.
- flag_we  in  1  write flag_wdata into set flag_wsel, clear its busy bit.
- flag_wsel  in  FSEL_W  set to write.
- flag_wdata  in  4  {N,Z,C,V}.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_cond  in  COND_WIDTH  condition code.
- req_fsel  in  FSEL_W  flag set to test.
- req_tag  in  TAG_WIDTH  request tag.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts result.
- resp_take  out  1  branch taken.
- resp_tag  out  TAG_WIDTH  tag of resolved request.
- busy  out  FLAG_SETS  scoreboard bits.
- eval_count  out  PERF_WIDTH  accepted requests, saturating.
- taken_count  out  PERF_WIDTH  accepted requests with take=1, saturating.

## Operation
- Codes: 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V; 8 C&!Z; 9 !C|Z; 10 N==V; 11 N!=V; 12 !Z&(N==V); 13 Z|(N!=V); 14 always; 15 and above never.
- Flag write: flag_we updates set flag_wsel and clears busy[flag_wsel]. Reserve sets busy[flag_rsel]. Reserve and write to the same set in the same cycle: data is written and busy stays 1, because the newer producer wins.
- Effective flags for evaluation: flag_wdata when flag_we && flag_wsel==req_fsel (bypass); otherwise the stored set.
- Hazard: hz = busy[req_fsel] && !(flag_we && flag_wsel==req_fsel). A reserve to req_fsel in the same cycle does not stall that cycle's request.
- req_ready = !hz && (!resp_valid || resp_ready). It is combinational and has no dependency on req_valid.
- Output register: on accept, resp_take, resp_tag and resp_valid=1 are loaded. resp_valid clears when resp_ready is high and there is no new accept. The result holds stable while resp_valid && !resp_ready.
- Counters increment on accept (taken_count only if take=1) and stick at all-ones.

## Timing
- Reset values: all flag sets 0000, busy 0, resp_valid 0, resp_take 0, resp_tag 0, counters 0. req_ready=1 after reset.
- Latency: request accepted at edge k gives a response visible after edge k, i.e. one cycle. Throughput is 1/cycle with resp_ready held high.
- Flag write at edge k is visible to stored-path reads after k. A same-cycle request uses the bypass, so there is zero stall.
- Asynchronous reset mid-operation drops any pending response and all scoreboard state immediately. No response is emitted for a request in flight.

## Test plan
- Reset, write set 1 = {N=0,Z=1,C=1,V=0}, request cond 9 fsel 1 tag 5 → next cycle resp_valid=1, take=1, tag=5. Repeat with cond 8 → take=0.
- Sweep all 16 codes × 16 flag values on set 0, comparing against the code table. Cond 14 → 1; cond 15 → 0. eval_count=256, and taken_count matches the model.
- Reserve set 2, then request fsel 2 → req_ready=0 for 3 cycles. flag_we set 2 with Z=1, plus the request with cond 0 in the same cycle → accepted (bypass), take=1.
- Reserve and write set 3 in the same cycle → busy[3] remains 1 and the request on set 3 stalls.
- Hold resp_ready=0 with two back-to-back requests → the first result is held stable and req_ready=0. Release → both results come in order with no loss.
- Assert rst_n low while resp_valid=1 and busy≠0 → outputs clear asynchronously. Drive 2^PERF_WIDTH+3 taken requests (PERF_WIDTH=4 build) → counters saturate at 15.
